// File: rtl/rioencoder_poll.sv
// ---------------------------------------------------------------------------
// rioencoder_poll
//   Request/timeout master for a half-duplex RS485 absolute encoder.
//   On every poll tick, while idle, it sends one 8N1 request byte (CMD) with
//   the transceiver driver enabled. It then holds the line for a guard time,
//   releases the driver and waits for the packet decoder to report a good
//   or a bad reply. Missing replies and corrupt replies are both counted in
//   err_count. A run of consecutive failures raises stale.
//
// Ports
//   clk        in   system clock, all logic on the rising edge
//   rst        in   asynchronous reset, active high
//   enable     in   polling enable (level)
//   rx_good    in   1-cycle pulse: decoder accepted a packet with a good checksum
//   rx_bad     in   1-cycle pulse: decoder end-of-packet with a bad checksum
//   tx         out  serial data to the transceiver, idle high
//   rw         out  transceiver driver enable, 1 = transmit
//   busy       out  high whenever a transaction is in progress
//   timeout    out  1-cycle pulse when the response window expires
//   err_count  out  timeouts plus bad packets, saturating at 16'hFFFF
//   stale      out  consecutive failed polls >= STALE_LIMIT
// ---------------------------------------------------------------------------
module rioencoder_poll #(
    parameter int         ClkFrequency = 12000000,
    parameter int         Baud         = 2000000,
    parameter int         POLL_HZ      = 1000,
    parameter int         TIMEOUT_US   = 200,
    parameter logic [7:0] CMD          = 8'h1A,
    parameter int         GUARD_BITS   = 1,
    parameter int         STALE_LIMIT  = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        rx_good,
    input  logic        rx_bad,
    output logic        tx,
    output logic        rw,
    output logic        busy,
    output logic        timeout,
    output logic [15:0] err_count,
    output logic        stale
);

    localparam int BIT_CYC   = ClkFrequency / Baud;
    localparam int POLL_CYC  = ClkFrequency / POLL_HZ;
    localparam int TO_CYC    = ClkFrequency / 1000000 * TIMEOUT_US;
    localparam int GUARD_CYC = GUARD_BITS * BIT_CYC;

    // One shared cycle counter times bit periods, the guard and the
    // response window, so it is sized for the longest of the three.
    localparam int CYC_MAX0 = (BIT_CYC > GUARD_CYC) ? BIT_CYC : GUARD_CYC;
    localparam int CYC_MAX  = (CYC_MAX0 > TO_CYC) ? CYC_MAX0 : TO_CYC;
    localparam int CYC_W    = (CYC_MAX > 2) ? $clog2(CYC_MAX) : 1;
    localparam int POLL_W   = (POLL_CYC > 2) ? $clog2(POLL_CYC) : 1;
    localparam int CONSEC_W = $clog2(STALE_LIMIT + 1);

    // Whole line frame, sent LSB first: start bit, CMD[0..7], stop bit.
    localparam logic [9:0] FRAME = {1'b1, CMD, 1'b0};

    typedef enum logic [1:0] {
        S_IDLE,
        S_TX,
        S_GUARD,
        S_WAIT
    } state_t;

    state_t                state_q, state_d;
    logic [POLL_W-1:0]     poll_q, poll_d;
    logic                  tick_q, tick_d;
    logic [CYC_W-1:0]      cyc_q, cyc_d;
    logic [3:0]            bit_q, bit_d;
    logic                  tx_q, tx_d;
    logic                  rw_q, rw_d;
    logic                  busy_q, busy_d;
    logic                  timeout_q, timeout_d;
    logic [15:0]           err_q, err_d;
    logic [CONSEC_W-1:0]   consec_q, consec_d;
    logic                  stale_q, stale_d;
    logic                  fail;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case statement can leave one unassigned (no latches).
        poll_d    = '0;
        state_d   = state_q;
        cyc_d     = cyc_q;
        bit_d     = bit_q;
        timeout_d = 1'b0;
        err_d     = err_q;
        consec_d  = consec_q;
        fail      = 1'b0;

        // Poll timebase: free-runs while enabled, parked at zero otherwise.
        if (enable) begin
            poll_d = (poll_q == POLL_W'(POLL_CYC - 1)) ? '0 : poll_q + 1'b1;
        end
        tick_d = enable && (poll_q == POLL_W'(POLL_CYC - 1));

        unique case (state_q)
            S_IDLE: begin
                if (tick_q) begin
                    state_d = S_TX;
                    cyc_d   = '0;
                    bit_d   = '0;
                end
            end
            S_TX: begin
                if (cyc_q == CYC_W'(BIT_CYC - 1)) begin
                    cyc_d = '0;
                    if (bit_q == 4'd9) begin
                        state_d = S_GUARD;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            S_GUARD: begin
                // A frame already on the wire always finishes; enable only
                // decides whether a reply is awaited afterwards.
                if (cyc_q == CYC_W'(GUARD_CYC - 1)) begin
                    cyc_d   = '0;
                    state_d = enable ? S_WAIT : S_IDLE;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            S_WAIT: begin
                // Priority: abort, then bad (also covers good+bad together),
                // then good, and only then the window expiring.
                if (!enable) begin
                    state_d = S_IDLE;
                end else if (rx_bad) begin
                    fail    = 1'b1;
                    state_d = S_IDLE;
                end else if (rx_good) begin
                    consec_d = '0;
                    state_d  = S_IDLE;
                end else if (cyc_q == CYC_W'(TO_CYC - 1)) begin
                    fail      = 1'b1;
                    timeout_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (fail) begin
            err_d    = (err_q == 16'hFFFF) ? err_q : err_q + 16'd1;
            consec_d = (consec_q == CONSEC_W'(STALE_LIMIT)) ? consec_q : consec_q + 1'b1;
        end

        // stale follows consec one cycle later.
        stale_d = (consec_q >= CONSEC_W'(STALE_LIMIT));

        // Line outputs are decoded from the next state so that the
        // registered pins change on the same edge as the state.
        busy_d = (state_d != S_IDLE);
        rw_d   = (state_d == S_TX) || (state_d == S_GUARD);
        tx_d   = (state_d == S_TX) ? FRAME[bit_d] : 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // Asynchronous reset idles the line at once, even mid-frame.
            state_q   <= S_IDLE;
            poll_q    <= '0;
            tick_q    <= 1'b0;
            cyc_q     <= '0;
            bit_q     <= '0;
            tx_q      <= 1'b1;
            rw_q      <= 1'b0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
            err_q     <= '0;
            consec_q  <= '0;
            stale_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            poll_q    <= poll_d;
            tick_q    <= tick_d;
            cyc_q     <= cyc_d;
            bit_q     <= bit_d;
            tx_q      <= tx_d;
            rw_q      <= rw_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
            err_q     <= err_d;
            consec_q  <= consec_d;
            stale_q   <= stale_d;
        end
    end

    assign tx        = tx_q;
    assign rw        = rw_q;
    assign busy      = busy_q;
    assign timeout   = timeout_q;
    assign err_count = err_q;
    assign stale     = stale_q;

endmodule

// File: tb/tb_rioencoder_poll.sv
// ---------------------------------------------------------------------------
// tb_rioencoder_poll
//   Self-checking bench for rioencoder_poll. The DUT runs at the default
//   clock, baud and timeout, with the poll rate raised to 4 kHz so the poll
//   period is 3000 cycles and the whole run stays short. The bench drives and
//   samples on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_rioencoder_poll;

    localparam int POLL_CYC = 12_000_000 / 4000;  // 3000
    localparam int TO_CYC   = 2400;
    localparam int RW_CYC   = 66;                 // (10 + 1 guard) * 6

    typedef enum int {K_NONE, K_GOOD, K_BAD, K_BOTH, K_QUIET} kind_t;

    typedef struct {
        string       name;
        kind_t       kind;
        int          delay;      // cycles after rw falls before the reply
        logic [15:0] exp_err;
        logic        exp_stale;
        int          exp_to;     // timeout pulses expected in this poll
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        rx_good;
    logic        rx_bad;
    logic        tx;
    logic        rw;
    logic        busy;
    logic        timeout;
    logic [15:0] err_count;
    logic        stale;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_to     = 0;
    logic [9:0]  frame_exp;
    vec_t        vecs[9];

    rioencoder_poll #(
        .POLL_HZ(4000)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .rx_good  (rx_good),
        .rx_bad   (rx_bad),
        .tx       (tx),
        .rw       (rw),
        .busy     (busy),
        .timeout  (timeout),
        .err_count(err_count),
        .stale    (stale)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (timeout === 1'b1) n_to <= n_to + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_rw(input string name);
        int n = 0;
        while (rw !== 1'b1 && n < POLL_CYC + 1000) begin
            step();
            n++;
        end
        check({name, ":rw_rise"}, rw, 1);
    endtask

    // Called on the first sample with rw high; returns on the sample where
    // rw should have just fallen. Optionally drops enable at sample drop_at.
    task automatic do_frame(input string name, input int drop_at);
        logic [9:0] bit_ok;
        logic       guard_ok;
        int         rw_cnt;
        bit_ok   = '1;
        guard_ok = 1'b1;
        rw_cnt   = 0;
        for (int i = 0; i < RW_CYC; i++) begin
            if (i == drop_at) enable = 1'b0;
            if (i < 60) begin
                if (tx !== frame_exp[i / 6]) bit_ok[i / 6] = 1'b0;
            end else if (tx !== 1'b1) begin
                guard_ok = 1'b0;
            end
            if (rw === 1'b1) rw_cnt++;
            step();
        end
        check({name, ":frame_bits_ok"}, bit_ok, 10'h3FF);
        check({name, ":guard_tx_high"}, guard_ok, 1);
        check({name, ":rw_high_cycles"}, rw_cnt, RW_CYC);
        check({name, ":rw_fall"}, rw, 0);
    endtask

    task automatic run_txn(input string name, input kind_t kind, input int delay,
                           input int drop_at, input logic [15:0] exp_err,
                           input logic exp_stale, input int exp_to);
        int k;
        int to0;
        wait_rw(name);
        do_frame(name, drop_at);
        to0 = n_to;
        k   = 0;
        if (drop_at >= 0) check({name, ":idle_after_guard"}, busy, 0);
        case (kind)
            K_NONE: begin
                while (timeout !== 1'b1 && k < TO_CYC + 200) begin
                    step();
                    k++;
                end
                check({name, ":timeout_latency"}, k, TO_CYC);
                check({name, ":busy_at_timeout"}, busy, 0);
            end
            K_GOOD, K_BAD, K_BOTH: begin
                repeat (delay) begin
                    step();
                    k++;
                end
                check({name, ":busy_before_reply"}, busy, 1);
                rx_good = (kind == K_GOOD) || (kind == K_BOTH);
                rx_bad  = (kind == K_BAD) || (kind == K_BOTH);
                step();
                k++;
                rx_good = 1'b0;
                rx_bad  = 1'b0;
                check({name, ":busy_after_reply"}, busy, 0);
            end
            default: ;
        endcase
        // Run past where the window would have ended before judging counters.
        while (k < TO_CYC + 10) begin
            step();
            k++;
        end
        check({name, ":err_count"}, err_count, exp_err);
        check({name, ":stale"}, stale, exp_stale);
        check({name, ":timeout_pulses"}, n_to - to0, exp_to);
        check({name, ":busy_end"}, busy, 0);
    endtask

    initial begin
        int n;
        frame_exp = 10'b1000110100;  // LSB first: 0,0,1,0,1,1,0,0,0,1

        vecs[0] = '{"good_500",  K_GOOD, 500,  16'd0, 1'b0, 0};
        vecs[1] = '{"to_1",      K_NONE, 0,    16'd1, 1'b0, 1};
        vecs[2] = '{"to_2",      K_NONE, 0,    16'd2, 1'b0, 1};
        vecs[3] = '{"to_3",      K_NONE, 0,    16'd3, 1'b1, 1};
        vecs[4] = '{"good_clr",  K_GOOD, 10,   16'd3, 1'b0, 0};
        vecs[5] = '{"bad_100",   K_BAD,  100,  16'd4, 1'b0, 0};
        vecs[6] = '{"good_2399", K_GOOD, 2399, 16'd4, 1'b0, 0};
        vecs[7] = '{"both_50",   K_BOTH, 50,   16'd5, 1'b0, 0};
        vecs[8] = '{"bad_2399",  K_BAD,  2399, 16'd6, 1'b0, 0};

        rst     = 1'b1;
        enable  = 1'b0;
        rx_good = 1'b0;
        rx_bad  = 1'b0;
        step();
        step();
        check("reset:tx", tx, 1);
        check("reset:rw", rw, 0);
        check("reset:busy", busy, 0);
        check("reset:timeout", timeout, 0);
        check("reset:err_count", err_count, 0);
        check("reset:stale", stale, 0);
        rst = 1'b0;
        step();

        // First start bit latency from raising enable.
        enable = 1'b1;
        n = 0;
        while (tx !== 1'b0 && n < POLL_CYC + 1000) begin
            step();
            n++;
        end
        check("first_start_latency", n, POLL_CYC + 1);

        foreach (vecs[i]) begin
            run_txn(vecs[i].name, vecs[i].kind, vecs[i].delay, -1,
                    vecs[i].exp_err, vecs[i].exp_stale, vecs[i].exp_to);
        end

        // Replies while idle are ignored.
        rx_bad = 1'b1;
        step();
        rx_bad  = 1'b0;
        rx_good = 1'b1;
        step();
        rx_good = 1'b0;
        step();
        check("idle_reply:err_count", err_count, 16'd6);
        check("idle_reply:busy", busy, 0);

        // Drop enable during frame bit 4: frame and guard finish, no error.
        run_txn("drop_tx_bit4", K_QUIET, 0, 26, 16'd6, 1'b0, 0);

        // Reset in the middle of a frame idles the line immediately.
        enable = 1'b1;
        wait_rw("rst_mid");
        repeat (20) step();
        check("rst_mid:tx_before", tx, 0);
        #2 rst = 1'b1;
        #1;
        check("rst_mid:tx", tx, 1);
        check("rst_mid:rw", rw, 0);
        check("rst_mid:busy", busy, 0);
        check("rst_mid:err_count", err_count, 0);
        step();
        enable = 1'b0;
        rst    = 1'b0;
        step();

        // Preload the error counter one below the top, then saturate it.
        enable = 1'b1;
        repeat (5) step();
        force dut.err_d = 16'hFFFE;
        step();
        release dut.err_d;
        check("sat:preload", err_count, 16'hFFFE);
        for (int i = 0; i < 3; i++) begin
            run_txn($sformatf("sat_to_%0d", i), K_NONE, 0, -1, 16'hFFFF, (i == 2), 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
